// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the multi-client SRAM controller.
package sram_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} sram_state_t;
    localparam int SRAM_DW = 16;
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;
    localparam int WS_W    = 4;
endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: combinational round-robin pick of the first eligible requester after ptr.
module sram_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [N-1:0]  elig;
    logic [IW-1:0] c;
    assign elig = req & ~mask;
    // c walks ptr+1, ptr+2, ... modulo N without leaving IW-bit arithmetic
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        c     = '0;
        for (int k = 0; k < N; k++) begin
            c = (ptr >= IW'(N - 1 - k)) ? ptr - IW'(N - 1 - k) : ptr + IW'(k + 1);
            if (!valid && elig[c]) begin
                valid    = 1'b1;
                idx      = c;
                grant[c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin multi-client controller for a 16-bit asynchronous SRAM
// with configurable wait states and byte-lane writes; every output is registered.
module sram_arb_ctrl
    import sram_pkg::*;
#(
    parameter int N_CLIENTS   = 2,
    parameter int AW          = 20,
    parameter int WAIT_STATES = 1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [N_CLIENTS-1:0]         req,
    input  logic [N_CLIENTS-1:0]         we,
    input  logic [N_CLIENTS*AW-1:0]      addr,
    input  logic [N_CLIENTS*SRAM_DW-1:0] wdata,
    input  logic [N_CLIENTS*2-1:0]       be,
    output logic [N_CLIENTS-1:0]         ack,
    output logic [SRAM_DW-1:0]           rdata,
    output logic                         busy,
    output logic [AW-1:0]                sram_addr,
    inout  wire  [SRAM_DW-1:0]           sram_data,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic                         sram_lb_n,
    output logic                         sram_ub_n
);
    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    sram_state_t          state, nstate;
    logic [WS_W-1:0]      cnt;
    logic [IW-1:0]        ptr, gidx;
    logic [N_CLIENTS-1:0] grant, l_grant, n_ack;
    logic                 gvalid, last, done, drive;
    logic                 n_ce_n, n_oe_n, n_we_n, n_lb_n, n_ub_n, n_drive;
    logic [SRAM_DW-1:0]   l_wdata;
    logic [1:0]           l_be, g_be, n_be;

    sram_rr_arbiter #(.N(N_CLIENTS)) u_arb (
        .req  (req),
        .mask (ack),
        .ptr  (ptr),
        .grant(grant),
        .idx  (gidx),
        .valid(gvalid)
    );

    assign g_be      = be[int'(gidx)*2 +: 2];
    assign n_be      = (state == IDLE) ? g_be : l_be;
    assign last      = cnt == WS_W'(WAIT_STATES);
    assign done      = (state == RD && last) || state == WR_HOLD;
    assign sram_data = drive ? l_wdata : 'z;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= (nstate == state) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:     nstate = gvalid ? (we[gidx] ? WR_SETUP : RD) : IDLE;
            RD:       nstate = last ? IDLE : RD;
            WR_SETUP: nstate = WR_PULSE;
            WR_PULSE: nstate = last ? WR_HOLD : WR_PULSE;
            default:  nstate = IDLE;
        endcase
    end

    // strobes are computed for the state being entered so the registers line up with it
    always_comb begin
        n_ce_n  = nstate == IDLE;
        n_oe_n  = nstate != RD;
        n_we_n  = nstate != WR_PULSE;
        n_drive = nstate inside {WR_SETUP, WR_PULSE, WR_HOLD};
        n_lb_n  = (nstate == IDLE) || (nstate != RD && !n_be[LANE_LO]);
        n_ub_n  = (nstate == IDLE) || (nstate != RD && !n_be[LANE_HI]);
        n_ack   = done ? l_grant : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            drive     <= 1'b0;
            ptr       <= IW'(N_CLIENTS - 1);
            l_grant   <= '0;
            l_wdata   <= '0;
            l_be      <= '0;
        end else begin
            ack       <= n_ack;
            busy      <= nstate != IDLE;
            sram_ce_n <= n_ce_n;
            sram_oe_n <= n_oe_n;
            sram_we_n <= n_we_n;
            sram_lb_n <= n_lb_n;
            sram_ub_n <= n_ub_n;
            drive     <= n_drive;
            if (state == RD && last) rdata <= sram_data;
            if (state == IDLE && gvalid) begin
                ptr       <= gidx;
                l_grant   <= grant;
                sram_addr <= addr[int'(gidx)*AW +: AW];
                l_wdata   <= wdata[int'(gidx)*SRAM_DW +: SRAM_DW];
                l_be      <= g_be;
            end
        end
    end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: randomized multi-client traffic against an SRAM model, with a
// transaction-level reference that predicts every registered output each cycle.
module tb_sram_arb_ctrl;
    localparam int N = 3;
    localparam int AW = 10;
    localparam int W = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [15:0] PROBE = 16'h5AA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] we = '0;
    logic [AW-1:0] c_addr [N];
    logic [15:0] c_wdata [N];
    logic [1:0] c_be [N];
    logic [N*AW-1:0] addr;
    logic [N*16-1:0] wdata;
    logic [N*2-1:0] be;
    logic [N-1:0] ack;
    logic [15:0] rdata;
    logic busy, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic [AW-1:0] sram_addr;
    wire [15:0] sram_data;

    logic [15:0] mem [DEPTH] = '{default: '0};
    logic [15:0] emem [DEPTH] = '{default: '0};
    logic poke = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [15:0] poke_d = '0;
    logic probe_en = 1'b1;

    // reference state: one access in flight, m_el edges since its grant
    logic m_busy = 1'b0;
    logic m_wr = 1'b0;
    int m_el = 0;
    int m_cli = 0;
    int ptr = N - 1;
    logic [N-1:0] m_ack = '0;
    logic [AW-1:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic [1:0] m_be = '0;
    logic [15:0] m_rdata = '0;

    int total = 0;
    int bad = 0;

    for (genvar g = 0; g < N; g++) begin : pk
        assign addr[g*AW +: AW] = c_addr[g];
        assign wdata[g*16 +: 16] = c_wdata[g];
        assign be[g*2 +: 2] = c_be[g];
    end

    sram_arb_ctrl #(.N_CLIENTS(N), .AW(AW), .WAIT_STATES(W)) dut (
        .Clk(clk), .Reset_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .rdata(rdata), .busy(busy), .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    // asynchronous SRAM plus a probe that only reads back intact when nobody else drives
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hzzzz;
    assign sram_data = probe_en ? PROBE : 16'hzzzz;

    always @(negedge clk) begin
        if (poke) mem[poke_a] <= poke_d;
        else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0] <= sram_data[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_data[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] nack;
        int c;
        if (!rst_n) begin
            m_busy = 1'b0; ptr = N - 1; m_ack = '0; m_rdata = '0; m_addr = '0; m_el = 0;
            probe_en <= 1'b1;
            return;
        end
        nack = '0;
        if (poke) emem[poke_a] = poke_d;
        if (m_busy) begin
            m_el++;
            if (m_el == (m_wr ? W + 3 : W + 1)) begin
                m_busy = 1'b0;
                nack[m_cli] = 1'b1;
                if (!m_wr) m_rdata = emem[m_addr];
                else begin
                    if (m_be[0]) emem[m_addr][7:0] = m_data[7:0];
                    if (m_be[1]) emem[m_addr][15:8] = m_data[15:8];
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (ptr + k) % N;
                if (!m_busy && req[c] && !m_ack[c]) begin
                    m_busy = 1'b1; m_el = 0; m_cli = c; m_wr = we[c];
                    m_addr = c_addr[c]; m_data = c_wdata[c]; m_be = c_be[c]; ptr = c;
                end
            end
        end
        m_ack = nack;
        probe_en <= !m_busy;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack", ack, m_ack);
            chk("busy", busy, m_busy);
            chk("rdata", rdata, m_rdata);
            chk("sram_addr", sram_addr, m_addr);
            chk("ce_n", sram_ce_n, !m_busy);
            chk("oe_n", sram_oe_n, !(m_busy && !m_wr));
            chk("we_n", sram_we_n, !(m_busy && m_wr && m_el >= 1 && m_el <= W + 1));
            chk("lb_n", sram_lb_n, !m_busy ? 1'b1 : (m_wr ? !m_be[0] : 1'b0));
            chk("ub_n", sram_ub_n, !m_busy ? 1'b1 : (m_wr ? !m_be[1] : 1'b0));
            chk("bus", sram_data, !m_busy ? PROBE : (m_wr ? m_data : emem[m_addr]));
        end
    end

    task automatic do_poke(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        poke = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        @(negedge clk);
        poke = 1'b0;
    endtask

    task automatic access(input int c, input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] b, output int lat, output logic [15:0] rd);
        int k;
        we[c] = w; c_addr[c] = a; c_wdata[c] = d; c_be[c] = b; req[c] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack[c] && k < 40);
        chk("ack_seen", ack[c], 1'b1);
        lat = k - 1;
        rd = rdata;
        req[c] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat, cnt, k, errs;
        int got [4];
        logic [15:0] rd;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0; c_wdata[i] = '0; c_be[i] = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ack", ack, 0);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b11111);
        chk("reset_bus", sram_data, PROBE);

        do_poke(10'h010, 16'hBEEF);
        do_poke(10'h020, 16'hABCD);
        do_poke(10'h040, 16'h7777);
        access(0, 1'b0, 10'h010, 16'h0000, 2'b00, lat, rd);
        chk("read_latency", lat, W + 1);
        chk("read_data", rd, 16'hBEEF);
        access(1, 1'b1, 10'h020, 16'h1234, 2'b01, lat, rd);
        chk("write_latency", lat, W + 3);
        chk("write_low_lane", mem[10'h020], 16'hAB34);
        access(2, 1'b1, 10'h040, 16'hFFFF, 2'b00, lat, rd);
        chk("be00_latency", lat, W + 3);
        chk("be00_unchanged", mem[10'h040], 16'h7777);

        // abort a write in the middle of its we_n pulse
        we[2] = 1'b1; c_addr[2] = 10'h030; c_wdata[2] = 16'hC0DE; c_be[2] = 2'b11; req[2] = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("pulse_before_reset", sram_we_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_ce_n", sram_ce_n, 1'b1);
        chk("abort_ack", ack, 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_bus", sram_data, PROBE);
        req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_poke(10'h030, emem[10'h030]);

        // every client reads continuously: grants must rotate starting from client 0
        for (int i = 0; i < N; i++) begin
            we[i] = 1'b0; c_addr[i] = AW'(i);
        end
        got = '{-1, -1, -1, -1};
        req = '1;
        cnt = 0;
        k = 0;
        while (cnt < 4 && k < 60) begin
            @(negedge clk);
            k++;
            for (int i = 0; i < N; i++) if (ack[i] && cnt < 4) begin
                got[cnt] = i;
                cnt++;
            end
            req = ~ack;
        end
        req = '0;
        chk("order_0", got[0], 0);
        chk("order_1", got[1], 1);
        chk("order_2", got[2], 2);
        chk("order_3", got[3], 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack[i]) req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    we[i] = 1'($urandom);
                    c_addr[i] = AW'($urandom_range(63));
                    c_wdata[i] = 16'($urandom);
                    c_be[i] = 2'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        k = 0;
        while ((req != '0 || m_busy) && k < 200) begin
            @(negedge clk);
            k++;
            req = req & ~ack;
        end
        chk("drain", {req != '0, m_busy}, 2'b00);
        repeat (2) @(negedge clk);
        errs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== emem[i]) errs++;
        chk("memory_image", errs, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
